stream_demux_1b_1to2: RTL and testbench

//  Registered 1-to-2 stream demultiplexer; the routing counterpart of the 2-to-1 mux.

---
 rtl/stream_demux_1b_1to2.sv | 75 +++++++
 tb/tb_stream_demux_1b_1to2.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1b_1to2.sv
// Registered 1-to-2 val/rdy stream demultiplexer.
// Each output owns a 2-entry FIFO so a stalled consumer never blocks the other port.
module stream_demux_1b_1to2 #(
  parameter int p_nbits = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  input  logic               in_sel,
  output logic               out0_val,
  input  logic               out0_rdy,
  output logic [p_nbits-1:0] out0_msg,
  output logic               out1_val,
  input  logic               out1_rdy,
  output logic [p_nbits-1:0] out1_msg
);

  logic [1:0]         r_count [2];
  logic [1:0]         r_head;
  logic [1:0]         r_tail;
  logic [p_nbits-1:0] r_mem   [2][2];

  logic [1:0]         w_sel;
  logic [1:0]         w_out_rdy;
  logic [1:0]         w_val;
  logic [1:0]         w_enq;
  logic [1:0]         w_deq;
  logic [p_nbits-1:0] w_msg   [2];

  // Outputs are gated by reset so the cleared view is presented during the reset cycle itself.
  always_comb begin
    w_sel     = {in_sel, ~in_sel};
    w_out_rdy = {out1_rdy, out0_rdy};
    in_rdy    = reset | (r_count[in_sel] != 2'd2);
    w_val     = '0;
    w_enq     = '0;
    w_deq     = '0;
    for (int k = 0; k < 2; k++) begin
      w_msg[k] = '0;
      w_val[k] = ~reset & (r_count[k] != 2'd0);
      w_enq[k] = ~reset & in_val & in_rdy & w_sel[k];
      w_deq[k] = w_val[k] & w_out_rdy[k];
      if (w_val[k]) w_msg[k] = r_mem[k][r_head[k]];
    end
  end

  assign out0_val = w_val[0];
  assign out0_msg = w_msg[0];
  assign out1_val = w_val[1];
  assign out1_msg = w_msg[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
      for (int k = 0; k < 2; k++) r_count[k] <= 2'd0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_enq[k]) r_tail[k] <= ~r_tail[k];
        if (w_deq[k]) r_head[k] <= ~r_head[k];
        r_count[k] <= r_count[k] + {1'b0, w_enq[k]} - {1'b0, w_deq[k]};
      end
    end
  end

  // NOTE: storage needs no reset; an empty FIFO never exposes its entries (msg forced to 0).
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (w_enq[k]) r_mem[k][r_tail[k]] <= in_msg;
    end
  end

endmodule

// File: tb/tb_stream_demux_1b_1to2.sv
// Self-checking bench: directed vector table for the corner sequences, then
// randomized traffic compared against a queue-based reference model.
module tb_stream_demux_1b_1to2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_val = 1'b0;
  logic in_rdy;
  logic [0:0] in_msg = '0;
  logic in_sel = 1'b0;
  logic out0_val, out1_val;
  logic out0_rdy = 1'b0, out1_rdy = 1'b0;
  logic [0:0] out0_msg, out1_msg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stream_demux_1b_1to2 #(.p_nbits(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .in_sel   (in_sel),
    .out0_val (out0_val),
    .out0_rdy (out0_rdy),
    .out0_msg (out0_msg),
    .out1_val (out1_val),
    .out1_rdy (out1_rdy),
    .out1_msg (out1_msg)
  );

  typedef struct {
    logic rst, val, msg, sel, r0, r1;
    logic e_rdy, e_v0, e_m0, e_v1, e_m1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic val, logic msg, logic sel, logic r0, logic r1,
                              logic e_rdy, logic e_v0, logic e_m0, logic e_v1, logic e_m1);
    vec_t v;
    v.rst = rst; v.val = val; v.msg = msg; v.sel = sel; v.r0 = r0; v.r1 = r1;
    v.e_rdy = e_rdy; v.e_v0 = e_v0; v.e_m0 = e_m0; v.e_v1 = e_v1; v.e_m1 = e_m1;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic val, input logic msg, input logic sel,
                       input logic r0, input logic r1);
    @(negedge clk);
    reset = rst; in_val = val; in_msg = msg; in_sel = sel; out0_rdy = r0; out1_rdy = r1;
    #1;
  endtask

  // Reference model: one queue per output port.
  logic q0[$];
  logic q1[$];

  initial begin
    //              rst val msg sel r0 r1   rdy v0 m0 v1 m1
    vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0));
    // single message to port 0, visible next cycle
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0));
    // fill port 0, in_rdy follows in_sel, port 1 still accepts
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,   1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   0, 1, 1, 1, 1));
    // drain: full FIFO refuses input even while its consumer is ready
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   0, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0));
    // alternating streaming
    vecs.push_back(mk(0, 1, 1, 0, 1, 1,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1,   1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 1,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0));
    // count==1 with simultaneous enq and deq
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0,   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0,   1, 1, 1, 0, 0));
    // fill both, then reset mid-operation
    vecs.push_back(mk(0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0,   1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,   0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1, 1,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1,   1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].val, vecs[i].msg, vecs[i].sel, vecs[i].r0, vecs[i].r1);
      check("in_rdy",   i, in_rdy,   vecs[i].e_rdy);
      check("out0_val", i, out0_val, vecs[i].e_v0);
      check("out0_msg", i, out0_msg, vecs[i].e_m0);
      check("out1_val", i, out1_val, vecs[i].e_v1);
      check("out1_msg", i, out1_msg, vecs[i].e_m1);
    end

    // Randomized traffic against the queue model; start from a clean reset.
    drive(1, 0, 0, 0, 0, 0);
    q0.delete();
    q1.delete();
    for (int i = 0; i < 3000; i++) begin
      logic rst, val, msg, sel, r0, r1;
      logic e_rdy, e_v0, e_m0, e_v1, e_m1;
      int sz_sel;
      rst = ($urandom_range(0, 99) == 0);
      val = ($urandom_range(0, 3) != 0);
      msg = 1'($urandom);
      sel = 1'($urandom);
      r0  = ($urandom_range(0, 2) != 0);
      r1  = ($urandom_range(0, 3) == 0);
      drive(rst, val, msg, sel, r0, r1);

      sz_sel = sel ? q1.size() : q0.size();
      e_rdy  = rst || (sz_sel < 2);
      e_v0   = !rst && (q0.size() > 0);
      e_v1   = !rst && (q1.size() > 0);
      e_m0   = e_v0 ? q0[0] : 1'b0;
      e_m1   = e_v1 ? q1[0] : 1'b0;
      check("rnd_in_rdy",   i, in_rdy,   e_rdy);
      check("rnd_out0_val", i, out0_val, e_v0);
      check("rnd_out0_msg", i, out0_msg, e_m0);
      check("rnd_out1_val", i, out1_val, e_v1);
      check("rnd_out1_msg", i, out1_msg, e_m1);

      if (rst) begin
        q0.delete();
        q1.delete();
      end else begin
        if (e_v0 && r0) void'(q0.pop_front());
        if (e_v1 && r1) void'(q1.pop_front());
        if (val && e_rdy) begin
          if (sel) q1.push_back(msg);
          else     q0.push_back(msg);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
